// File: rtl/gpi_debounce.sv
// gpi_debounce: synchronize, tick-sample and debounce general-purpose inputs.
// Edge pulses, sticky change flags and irq exist only with GPI_DEBOUNCE_EDGE_IRQ_EN.
module gpi_debounce #(
    parameter int Width       = 13,
    parameter int TickCycles  = 50000,
    parameter int StableTicks = 4
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] gp_raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic [Width-1:0] changed_o,
    input  logic [Width-1:0] changed_clr_i,
    output logic             irq_o
);

    localparam int PW = $clog2(TickCycles);
    localparam logic [PW-1:0] PreMax = PW'(TickCycles - 1);
    localparam logic [3:0] StableM1 = 4'(StableTicks - 1);

    logic [Width-1:0]      sync1_q;
    logic [Width-1:0]      sync_q;
    logic [PW-1:0]         pre_q;
    logic                  tick;
    logic [Width-1:0][3:0] cnt_q;
    logic [Width-1:0][3:0] cnt_d;
    logic [Width-1:0]      gp_q;
    logic [Width-1:0]      toggle;

    assign tick = (pre_q == PreMax);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync1_q <= '0;
            sync_q  <= '0;
            pre_q   <= '0;
        end else begin
            sync1_q <= gp_raw_i;
            sync_q  <= sync1_q;
            pre_q   <= tick ? '0 : pre_q + 1'b1;
        end
    end

    // cnt+1 == StableTicks is the same as cnt == StableTicks-1
    always_comb begin
        toggle = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < Width; i++) begin
            if (sync_q[i] == gp_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == StableM1) begin
                    toggle[i] = 1'b1;
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            cnt_q <= '0;
            gp_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            gp_q  <= gp_q ^ toggle;
        end
    end

    assign gp_o = gp_q;

`ifdef GPI_DEBOUNCE_EDGE_IRQ_EN
    logic [Width-1:0] rise_q;
    logic [Width-1:0] fall_q;
    logic [Width-1:0] changed_q;

    // Pulses land on the same edge as the gp_q toggle; set beats clear.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= '0;
        end else begin
            rise_q    <= toggle & ~gp_q;
            fall_q    <= toggle & gp_q;
            changed_q <= (changed_q & ~changed_clr_i) | rise_q | fall_q;
        end
    end

    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign changed_o = changed_q;
    assign irq_o     = |changed_q;
`else
    logic unused_clr;

    assign unused_clr = ^changed_clr_i;
    assign rise_o     = '0;
    assign fall_o     = '0;
    assign changed_o  = '0;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// tb_gpi_debounce: scoreboard bench for gpi_debounce (TickCycles=4, StableTicks=3).
// Edge/irq expectations follow GPI_DEBOUNCE_EDGE_IRQ_EN.
module tb_gpi_debounce;

    localparam int W      = 13;
    localparam int TC     = 4;
    localparam int ST     = 3;
    localparam int LatMin = 2 + (ST - 1) * TC + 1;
    localparam int LatMax = 2 + ST * TC;
    // prescaler restarts at 0: third tick seen on edge 12 after release
    localparam int LatRst = 12;
`ifdef GPI_DEBOUNCE_EDGE_IRQ_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif
    localparam logic [W-1:0] Ones = '1;
    localparam logic [W-1:0] EMask = EdgeEn ? Ones : '0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw = '0;
    logic [W-1:0] clr = '0;
    logic [W-1:0] gp;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] changed;
    logic         irq;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    gpi_debounce #(
        .Width      (W),
        .TickCycles (TC),
        .StableTicks(ST)
    ) dut (
        .clk_sys_i    (clk),
        .rst_sys_ni   (rst_n),
        .gp_raw_i     (raw),
        .gp_o         (gp),
        .rise_o       (rise),
        .fall_o       (fall),
        .changed_o    (changed),
        .changed_clr_i(clr),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_cmp(input logic [31:0] got);
        exp_t e;
        chk("sb_depth", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk(e.tag, got, e.val);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gp(input logic [W-1:0] mask, input logic [W-1:0] tgt,
                           output int lat);
        lat = 0;
        while (((gp & mask) !== (tgt & mask)) && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic clr_pulse(input logic [W-1:0] m);
        clr = m;
        step();
        clr = '0;
    endtask

    function automatic logic [31:0] in_win(input int lat);
        return 32'(lat >= LatMin && lat <= LatMax);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        logic seen_gp;
        logic seen_rise;

        // reset held with every switch on
        rst_n = 1'b0;
        raw   = Ones;
        sb_push("rst_gp", 32'd0);
        sb_push("rst_rise", 32'd0);
        sb_push("rst_fall", 32'd0);
        sb_push("rst_changed", 32'd0);
        sb_push("rst_irq", 32'd0);
        repeat (3) step();
        sb_cmp(32'(gp));
        sb_cmp(32'(rise));
        sb_cmp(32'(fall));
        sb_cmp(32'(changed));
        sb_cmp(32'(irq));

        rst_n = 1'b1;
        sb_push("rel_lat", 32'(LatRst));
        sb_push("rel_gp", 32'(Ones));
        sb_push("rel_rise", 32'(EMask));
        sb_push("rel_rise_end", 32'd0);
        sb_push("rel_changed", 32'(EMask));
        sb_push("rel_irq", 32'(EdgeEn));
        wait_gp(Ones, Ones, lat);
        sb_cmp(32'(lat));
        sb_cmp(32'(gp));
        sb_cmp(32'(rise));
        step();
        sb_cmp(32'(rise));
        sb_cmp(32'(changed));
        sb_cmp(32'(irq));
        clr_pulse(Ones);
        sb_push("clr_all", 32'd0);
        sb_cmp(32'(changed));

        // all switches off together
        raw = '0;
        sb_push("all_fall_lat", 32'd1);
        sb_push("all_fall", 32'(EMask));
        wait_gp(Ones, '0, lat);
        sb_cmp(in_win(lat));
        sb_cmp(32'(fall));
        step();
        clr_pulse(Ones);

        // glitch on bit 1
        raw[1]    = 1'b1;
        seen_gp   = 1'b0;
        seen_rise = 1'b0;
        sb_push("glitch_gp", 32'd0);
        sb_push("glitch_rise", 32'd0);
        sb_push("glitch_changed", 32'd0);
        for (int i = 0; i < 22; i++) begin
            if (i == 6) raw[1] = 1'b0;
            step();
            seen_gp   |= gp[1];
            seen_rise |= rise[1];
        end
        sb_cmp(32'(seen_gp));
        sb_cmp(32'(seen_rise));
        sb_cmp(32'(changed[1]));

        // steady change on bit 0
        raw[0] = 1'b1;
        sb_push("b0_lat", 32'd1);
        sb_push("b0_gp", 32'd1);
        sb_push("b0_rise", 32'(EdgeEn));
        sb_push("b0_rise_end", 32'd0);
        sb_push("b0_irq", 32'(EdgeEn));
        sb_push("b0_others", 32'd0);
        wait_gp(13'd1, 13'd1, lat);
        sb_cmp(in_win(lat));
        sb_cmp(32'(gp[0]));
        sb_cmp(32'(rise[0]));
        step();
        sb_cmp(32'(rise[0]));
        sb_cmp(32'(irq));
        sb_cmp(32'(gp[W-1:1]));
        clr_pulse(Ones);
        raw[0] = 1'b0;
        wait_gp(13'd1, 13'd0, lat);
        step();
        clr_pulse(Ones);

        // clear collides with fall on bit 2
        raw[2] = 1'b1;
        wait_gp(13'd4, 13'd4, lat);
        step();
        clr_pulse(Ones);
        raw[2] = 1'b0;
        sb_push("b2_fall", 32'(EdgeEn));
        sb_push("b2_coll_changed", 32'(EdgeEn));
        sb_push("b2_coll_irq", 32'(EdgeEn));
        sb_push("b2_clr_changed", 32'd0);
        sb_push("b2_clr_irq", 32'd0);
        wait_gp(13'd4, 13'd0, lat);
        sb_cmp(32'(fall[2]));
        clr_pulse(13'd4);
        sb_cmp(32'(changed[2]));
        sb_cmp(32'(irq));
        clr_pulse(13'd4);
        sb_cmp(32'(changed[2]));
        sb_cmp(32'(irq));

        // reset with bit 3 two ticks into its count
        raw[3] = 1'b1;
        repeat (10) step();
        sb_push("b3_pre_rst", 32'd0);
        sb_push("b3_in_rst", 32'd0);
        sb_push("b3_lat", 32'(LatRst));
        sb_push("b3_gp", 32'd1);
        sb_cmp(32'(gp[3]));
        rst_n = 1'b0;
        repeat (2) step();
        sb_cmp(32'(gp));
        rst_n = 1'b1;
        wait_gp(13'd8, 13'd8, lat);
        sb_cmp(32'(lat));
        sb_cmp(32'(gp[3]));

        sb_push("sb_drained", 32'd0);
        sb_cmp(32'(sb_q.size() - 1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpi_debounce.md
GPI_DEBOUNCE -- requirements
Module: gpi_debounce

Interface
- REQ-001: The block SHALL have parameter Width, default 13, giving the number of general-purpose input bits.
- REQ-002: The block SHALL have parameter TickCycles, default 50000, giving the sample-tick period in clk_sys_i cycles (1 ms at 50 MHz); legal range is 2 or more.
- REQ-003: The block SHALL have parameter StableTicks, default 4, giving the consecutive differing ticks needed to accept a change; legal range is 1 to 15.
- REQ-004: The block SHALL have port clk_sys_i, input, 1 bit, the system clock (the one clock).
- REQ-005: The block SHALL have port rst_sys_ni, input, 1 bit, the system reset, asynchronous and active-low.
- REQ-006: The block SHALL have port gp_raw_i, input, Width bits, asynchronous raw switch levels (already inverted, so 1 means on).
- REQ-007: The block SHALL have port gp_o, output, Width bits, the debounced levels that feed the system GPI.
- REQ-008: The block SHALL have port rise_o, output, Width bits, a one-cycle pulse per bit on each debounced 0->1 transition.
- REQ-009: The block SHALL have port fall_o, output, Width bits, a one-cycle pulse per bit on each debounced 1->0 transition.
- REQ-010: The block SHALL have port changed_o, output, Width bits, a sticky per-bit flag that a change occurred.
- REQ-011: The block SHALL have port changed_clr_i, input, Width bits, write-1-to-clear for changed_o.
- REQ-012: The block SHALL have port irq_o, output, 1 bit, the OR of changed_o.

Function
- REQ-013: Each gp_raw_i bit SHALL pass through a two-flop synchronizer (sync) before any other use.
- REQ-014: A shared prescaler SHALL count from 0 to TickCycles-1 and wrap to 0, asserting an internal tick for exactly one cycle when the count equals TickCycles-1.
- REQ-015: Each bit SHALL have a 4-bit stability counter cnt, which clears in any cycle where sync equals gp_o, regardless of tick.
- REQ-016: On a tick where sync differs from gp_o, if cnt+1 equals StableTicks then gp_o SHALL toggle on the next clock edge and cnt SHALL clear; otherwise cnt SHALL increment.
- REQ-017: Between ticks, a non-zero cnt SHALL hold its value while sync differs from gp_o.
- REQ-018: Latency from a gp_raw_i change to gp_o SHALL be at least 2+(StableTicks-1)*TickCycles+1 cycles and at most 2+StableTicks*TickCycles cycles.
- REQ-019: Any glitch shorter than (StableTicks-1)*TickCycles cycles SHALL never change gp_o.
- REQ-020: rise_o[i] and fall_o[i] SHALL be registered and asserted in the same cycle that gp_o[i] first shows its new value.
- REQ-021: changed_o[i] SHALL set on rise_o[i] or fall_o[i] and clear on changed_clr_i[i]; when set and clear occur in the same cycle, set SHALL win.
- REQ-022: irq_o SHALL be the combinational OR of all changed_o bits.
- REQ-023: Bits SHALL be fully independent, and simultaneous changes on multiple bits SHALL each produce their own pulses in the same cycle.

Reset
- REQ-024: While rst_sys_ni=0, the synchronizers, prescaler, cnt, gp_o, rise_o, fall_o and changed_o SHALL all be 0, and irq_o SHALL be 0.
- REQ-025: On a reset applied mid-count, all accumulated stability SHALL be discarded, and after release a change SHALL need a full StableTicks ticks.
- REQ-026: A switch already on at reset release SHALL produce a normal debounced rise, including its rise_o pulse and changed_o set.

Configuration
- REQ-027: With macro GPI_DEBOUNCE_EDGE_IRQ_EN defined, the edge, sticky and interrupt logic of REQ-020 to REQ-022 SHALL be present.
- REQ-028: Without GPI_DEBOUNCE_EDGE_IRQ_EN, rise_o, fall_o, changed_o and irq_o SHALL be constant 0, changed_clr_i SHALL be ignored, and gp_o behaviour SHALL be identical to the macro-defined build.

Verification (bench uses TickCycles=4, StableTicks=3)
- REQ-029: Reset check: hold rst_sys_ni=0 with gp_raw_i all ones -> gp_o, rise_o, fall_o, changed_o and irq_o are all 0; after release, gp_o goes to all ones between 11 and 14 cycles later, with one rise_o pulse on all 13 bits.
- REQ-030: Glitch rejection: gp_raw_i[1]=1 for 6 cycles then 0 -> gp_o[1] stays 0, no rise_o pulse, and changed_o[1]=0.
- REQ-031: Steady change: gp_raw_i[0] 0->1 and held -> gp_o[0]=1 within 14 cycles and not before 11, with rise_o[0] high for exactly 1 cycle.
- REQ-032: Sticky collision: pulse changed_clr_i[2] in the same cycle as fall_o[2] -> changed_o[2] remains 1 and irq_o=1; a later clr pulse gives changed_o[2]=0 and irq_o=0.
- REQ-033: Reset mid-count: assert reset when cnt[3]=2, then release with gp_raw_i[3] still 1 -> gp_o[3] rises at 11 to 14 cycles after release, not earlier.
- REQ-034: Macro off: repeat REQ-031 without the macro -> gp_o timing is identical, and rise_o, changed_o and irq_o are all 0 throughout.
